// File: rtl/io_rr_arbiter.sv
// io_rr_arbiter: round-robin arbiter that gives I/O channels exclusive use of one memory bus,
// with an ack timeout per transaction.
module io_rr_arbiter #(
    parameter int WORD_SIZE = 16,
    parameter int IO_COUNT  = 4,
    parameter int TIMEOUT   = 255
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [IO_COUNT-1:0]           reqVec,
    input  logic [IO_COUNT-1:0]           dirVec,
    input  logic [IO_COUNT*WORD_SIZE-1:0] addrArr,
    input  logic [IO_COUNT*WORD_SIZE-1:0] wdataArr,
    output logic [IO_COUNT-1:0]           gntVec,
    output logic [IO_COUNT-1:0]           doneVec,
    output logic [IO_COUNT-1:0]           errVec,
    output logic [WORD_SIZE-1:0]          rdata,
    output logic                          memReq,
    output logic                          memDir,
    output logic [WORD_SIZE-1:0]          memAdd,
    output logic [WORD_SIZE-1:0]          memDataOut,
    input  logic [WORD_SIZE-1:0]          memDataIn,
    input  logic                          memAck
);
    localparam int IW = $clog2(IO_COUNT);
    localparam int CW = IW + 1;
    typedef enum logic [1:0] {IDLE, BUS, DONE} state_t;
    state_t                state_q;
    logic [IW-1:0]         ptr_q, idx_q, idx_d;
    logic [CW-1:0]         c;
    logic [15:0]           tcnt_q;
    logic                  dir_q, req_q;
    logic [WORD_SIZE-1:0]  addr_q, wdata_q, rdata_q;
    logic [IO_COUNT-1:0]   gnt_q, done_q, err_q;
    logic [WORD_SIZE-1:0]  addr_a [IO_COUNT];
    logic [WORD_SIZE-1:0]  wdata_a [IO_COUNT];
    for (genvar g = 0; g < IO_COUNT; g++) begin : g_unpack
        assign addr_a[g]  = addrArr[g*WORD_SIZE +: WORD_SIZE];
        assign wdata_a[g] = wdataArr[g*WORD_SIZE +: WORD_SIZE];
    end
    // Scan downward so the requester closest to ptr (smallest offset) wins.
    always_comb begin
        idx_d = '0;
        c = '0;
        for (int k = IO_COUNT - 1; k >= 0; k--) begin
            c = {1'b0, ptr_q} + CW'(k);
            c = c >= CW'(IO_COUNT) ? c - CW'(IO_COUNT) : c;
            idx_d = reqVec[c[IW-1:0]] ? c[IW-1:0] : idx_d;
        end
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            idx_q   <= '0;
            tcnt_q  <= '0;
            dir_q   <= 1'b0;
            req_q   <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            gnt_q   <= '0;
            done_q  <= '0;
            err_q   <= '0;
        end else begin
            done_q <= '0;
            err_q  <= '0;
            case (state_q)
                IDLE: if (|reqVec) begin
                    idx_q   <= idx_d;
                    dir_q   <= dirVec[idx_d];
                    addr_q  <= addr_a[idx_d];
                    wdata_q <= wdata_a[idx_d];
                    tcnt_q  <= '0;
                    gnt_q   <= IO_COUNT'(1) << idx_d;
                    req_q   <= 1'b1;
                    state_q <= BUS;
                end
                BUS: begin
                    tcnt_q <= tcnt_q + 16'd1;
                    // An ack on the final allowed cycle still counts as success.
                    if (memAck) begin
                        rdata_q <= dir_q ? rdata_q : memDataIn;
                        done_q  <= gnt_q;
                        req_q   <= 1'b0;
                        state_q <= DONE;
                    end else if (tcnt_q + 16'd1 == 16'(TIMEOUT)) begin
                        err_q   <= gnt_q;
                        req_q   <= 1'b0;
                        state_q <= DONE;
                    end
                end
                DONE: begin
                    ptr_q   <= idx_q == IW'(IO_COUNT - 1) ? '0 : idx_q + 1'b1;
                    gnt_q   <= '0;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end
    assign gntVec     = gnt_q;
    assign doneVec    = done_q;
    assign errVec     = err_q;
    assign rdata      = rdata_q;
    assign memReq     = req_q;
    assign memDir     = dir_q;
    assign memAdd     = addr_q;
    assign memDataOut = wdata_q;
endmodule

// File: tb/tb_io_rr_arbiter.sv
// tb_io_rr_arbiter: scoreboard bench for io_rr_arbiter; stimulus queues expected grants and
// completions, a negedge monitor pops and compares them as the DUT presents them.
module tb_io_rr_arbiter;
    logic        clk = 0, rst = 1;
    logic [3:0]  reqVec = 0, dirVec = 0, gntVec, doneVec, errVec;
    logic [63:0] addrArr = 0, wdataArr = 0;
    logic [15:0] rdata, memAdd, memDataOut, memDataIn = 0;
    logic        memReq, memDir, memAck = 0;
    int          checks = 0, fails = 0, cyc = 0;
    typedef struct {int ch; logic [15:0] addr; logic dir; logic [15:0] wdata;} gnt_t;
    typedef struct {bit err; int ch; logic [15:0] rd;} cpl_t;
    gnt_t gq[$];
    cpl_t cq[$];
    gnt_t gexp;
    cpl_t cexp;
    logic prev_req = 0;

    io_rr_arbiter #(.WORD_SIZE(16), .IO_COUNT(4), .TIMEOUT(8)) dut (
        .clk(clk), .rst(rst), .reqVec(reqVec), .dirVec(dirVec), .addrArr(addrArr),
        .wdataArr(wdataArr), .gntVec(gntVec), .doneVec(doneVec), .errVec(errVec),
        .rdata(rdata), .memReq(memReq), .memDir(memDir), .memAdd(memAdd),
        .memDataOut(memDataOut), .memDataIn(memDataIn), .memAck(memAck)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        chk("onehot", {61'd0, $onehot0(gntVec), $onehot0(doneVec), $onehot0(errVec)}, 64'd7);
        if (memReq && !prev_req) begin
            if (gq.size() == 0) chk("unexpected_grant", gntVec, 0);
            else begin
                gexp = gq.pop_front();
                chk("gnt", gntVec, 64'(1 << gexp.ch));
                chk("addr", memAdd, gexp.addr);
                chk("dir", memDir, gexp.dir);
                chk("wdata", memDataOut, gexp.wdata);
            end
        end
        if (|{doneVec, errVec}) begin
            if (cq.size() == 0) chk("unexpected_cpl", {doneVec, errVec}, 0);
            else begin
                cexp = cq.pop_front();
                chk("done", doneVec, cexp.err ? 0 : 64'(1 << cexp.ch));
                chk("err", errVec, cexp.err ? 64'(1 << cexp.ch) : 0);
                chk("rdata", rdata, cexp.rd);
            end
        end
        prev_req = memReq;
    end

    task automatic set_ch(input int ch, input logic [15:0] a, input logic [15:0] w);
        addrArr[ch*16 +: 16]  = a;
        wdataArr[ch*16 +: 16] = w;
    endtask

    // Waits for the bus, acks on BUS cycle ack_at (0 = never), scrambles channel inputs after the latch.
    task automatic serve(input int ack_at, input logic [15:0] d, output int n);
        logic [15:0] a0, w0;
        logic        d0;
        int          t;
        t = 0;
        n = 0;
        while (!memReq && t < 20) begin
            @(negedge clk);
            t++;
        end
        chk("memReq_rise", memReq, 1);
        a0 = memAdd;
        w0 = memDataOut;
        d0 = memDir;
        while (memReq && n < 300) begin
            n++;
            if (n > 1) chk("bus_stable", {memDir, memAdd, memDataOut}, {d0, a0, w0});
            if (n == 1) begin
                addrArr  = ~addrArr;
                wdataArr = ~wdataArr;
                dirVec   = ~dirVec;
            end
            memDataIn = d;
            memAck    = (n == ack_at);
            @(negedge clk);
        end
        memAck = 0;
        reqVec = 0;
        @(negedge clk);
        chk("pulse_width", {gntVec, doneVec, errVec}, 0);
    endtask

    initial begin
        int n, t0, last;
        repeat (3) @(negedge clk);
        chk("rst_outs", {gntVec, doneVec, errVec, memReq, memDir}, 0);
        chk("rst_bus", {memAdd, memDataOut, rdata}, 0);
        rst = 0;
        for (int i = 0; i < 4; i++) set_ch(i, 16'h1000 + 16'(i), 16'h2000 + 16'(i));
        for (int k = 0; k < 5; k++) begin
            gq.push_back('{k % 4, 16'h1000 + 16'(k % 4), 1'b0, 16'h2000 + 16'(k % 4)});
            cq.push_back('{1'b0, k % 4, 16'h1234});
        end
        dirVec = 0;
        memDataIn = 16'h1234;
        memAck = 1;
        reqVec = 4'hF;
        last = 0;
        for (int k = 0; k < 5; k++) begin
            t0 = 0;
            do begin
                @(negedge clk);
                t0++;
            end while (doneVec == 0 && t0 < 20);
            chk("fair_done_seen", {63'd0, |doneVec}, 1);
            if (k > 0) chk("fair_spacing", 64'(cyc - last), 3);
            last = cyc;
        end
        reqVec = 0;
        memAck = 0;
        @(negedge clk);
        dirVec = 0;
        set_ch(1, 16'h0040, 16'h1111);
        gq.push_back('{1, 16'h0040, 1'b0, 16'h1111});
        cq.push_back('{1'b0, 1, 16'hBEEF});
        reqVec = 4'b0010;
        serve(3, 16'hBEEF, n);
        chk("read_bus_cycles", n, 3);
        dirVec = 4'b0100;
        set_ch(2, 16'h0200, 16'hA5A5);
        gq.push_back('{2, 16'h0200, 1'b1, 16'hA5A5});
        cq.push_back('{1'b1, 2, 16'hBEEF});
        reqVec = 4'b0100;
        serve(0, 16'h0000, n);
        chk("timeout_bus_cycles", n, 8);
        dirVec = 4'b1000;
        set_ch(3, 16'h0300, 16'h3333);
        gq.push_back('{3, 16'h0300, 1'b1, 16'h3333});
        cq.push_back('{1'b0, 3, 16'hBEEF});
        reqVec = 4'b1000;
        serve(1, 16'hFFFF, n);
        chk("wrap_ch3_cycles", n, 1);
        dirVec = 0;
        set_ch(0, 16'h0010, 16'h0000);
        set_ch(3, 16'h0300, 16'h3333);
        gq.push_back('{0, 16'h0010, 1'b0, 16'h0000});
        cq.push_back('{1'b0, 0, 16'hC0DE});
        reqVec = 4'b1001;
        serve(1, 16'hC0DE, n);
        dirVec = 0;
        set_ch(0, 16'h0010, 16'h0000);
        set_ch(3, 16'h0300, 16'h3333);
        gq.push_back('{3, 16'h0300, 1'b0, 16'h3333});
        cq.push_back('{1'b0, 3, 16'h3C3C});
        reqVec = 4'b1001;
        serve(1, 16'h3C3C, n);
        dirVec = 0;
        set_ch(1, 16'h0041, 16'h0000);
        gq.push_back('{1, 16'h0041, 1'b0, 16'h0000});
        cq.push_back('{1'b0, 1, 16'h5A5A});
        reqVec = 4'b0010;
        serve(8, 16'h5A5A, n);
        chk("race_bus_cycles", n, 8);
        dirVec = 4'b0100;
        set_ch(2, 16'h0222, 16'h2222);
        gq.push_back('{2, 16'h0222, 1'b1, 16'h2222});
        reqVec = 4'b0100;
        t0 = 0;
        do begin
            @(negedge clk);
            t0++;
        end while (!memReq && t0 < 20);
        chk("abort_req_seen", memReq, 1);
        @(negedge clk);
        rst = 1;
        @(negedge clk);
        chk("abort_outs", {memReq, gntVec, doneVec, errVec, memDir}, 0);
        chk("abort_bus", {memAdd, memDataOut, rdata}, 0);
        rst = 0;
        dirVec = 0;
        for (int i = 0; i < 4; i++) set_ch(i, 16'h0ABC + 16'(i), 16'h0000);
        gq.push_back('{0, 16'h0ABC, 1'b0, 16'h0000});
        cq.push_back('{1'b0, 0, 16'h7777});
        reqVec = 4'b1111;
        serve(1, 16'h7777, n);
        repeat (2) @(negedge clk);
        chk("queues_empty", 64'(gq.size() + cq.size()), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule
